// File: rtl/caf_ctrl_if.sv
// caf_ctrl_if: handshake bundle between caf_ctrl and one x_corr instance.
//   xc_m_axis_tvalid  controller -> x_corr : sample beat valid
//   xc_s_axis_tready  x_corr -> controller : x_corr can take a sample beat
//   xc_s_axis_tvalid  x_corr -> controller : arg-max result valid
//   xc_out_max        x_corr -> controller : result magnitude
//   xc_index          x_corr -> controller : result lag index
//   xc_m_axis_tready  controller -> x_corr : controller accepts the result
// master = caf_ctrl side, slave = x_corr side.
interface caf_ctrl_if #(
   parameter int unsigned OutMaxBits        = 5,
   parameter int unsigned LengthCounterBits = 3
);
   logic                         xc_m_axis_tvalid;
   logic                         xc_s_axis_tready;
   logic                         xc_s_axis_tvalid;
   logic [OutMaxBits-1:0]        xc_out_max;
   logic [LengthCounterBits-1:0] xc_index;
   logic                         xc_m_axis_tready;

   modport master (
      output xc_m_axis_tvalid,
      output xc_m_axis_tready,
      input  xc_s_axis_tready,
      input  xc_s_axis_tvalid,
      input  xc_out_max,
      input  xc_index
   );

   modport slave (
      input  xc_m_axis_tvalid,
      input  xc_m_axis_tready,
      output xc_s_axis_tready,
      output xc_s_axis_tvalid,
      output xc_out_max,
      output xc_index
   );
endinterface

// File: rtl/caf_ctrl.sv
// caf_ctrl: sweeps one x_corr instance over FreqBins frequency bins and keeps the
// strongest correlation peak (magnitude, lag, bin) seen during the sweep.
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   start       one-cycle sweep request, honoured only while idle
//   busy        high from the cycle after an accepted start until done
//   done        one-cycle pulse at the end of a sweep
//   freq_index  current bin for the upstream frequency shifter
//   x_addr      reference sample buffer address
//   y_addr      received sample buffer address
//   best_max    largest magnitude found
//   best_index  lag index of best_max
//   best_freq   bin of best_max
//   xc          handshake bundle to x_corr (master side)
module caf_ctrl #(
   parameter int unsigned Length            = 5,
   parameter int unsigned LengthCounterBits = 3,
   parameter int unsigned FreqBins          = 4,
   parameter int unsigned FreqBits          = 2,
   parameter int unsigned OutMaxBits        = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic [FreqBits-1:0]          freq_index,
   output logic [LengthCounterBits-1:0] x_addr,
   output logic [LengthCounterBits-1:0] y_addr,
   output logic [OutMaxBits-1:0]        best_max,
   output logic [LengthCounterBits-1:0] best_index,
   output logic [FreqBits-1:0]          best_freq,
   caf_ctrl_if.master                   xc
);

   localparam logic [LengthCounterBits-1:0] LastCnt  = LengthCounterBits'(Length - 1);
   localparam logic [FreqBits-1:0]          LastFreq = FreqBits'(FreqBins - 1);

   typedef enum logic [2:0] {StIdle, StFeed, StWait, StUpdate, StDone} state_e;

   state_e                       r_state,    w_state;
   logic [LengthCounterBits-1:0] r_cnt,      w_cnt;
   logic [FreqBits-1:0]          r_freq,     w_freq;
   logic                         r_first,    w_first;
   logic [OutMaxBits-1:0]        r_res_max,  w_res_max;
   logic [LengthCounterBits-1:0] r_res_idx,  w_res_idx;
   logic [OutMaxBits-1:0]        r_best_max, w_best_max;
   logic [LengthCounterBits-1:0] r_best_idx, w_best_idx;
   logic [FreqBits-1:0]          r_best_frq, w_best_frq;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_freq     <= '0;
         r_first    <= 1'b0;
         r_res_max  <= '0;
         r_res_idx  <= '0;
         r_best_max <= '0;
         r_best_idx <= '0;
         r_best_frq <= '0;
      end else begin
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_freq     <= w_freq;
         r_first    <= w_first;
         r_res_max  <= w_res_max;
         r_res_idx  <= w_res_idx;
         r_best_max <= w_best_max;
         r_best_idx <= w_best_idx;
         r_best_frq <= w_best_frq;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_freq     = r_freq;
      w_first    = r_first;
      w_res_max  = r_res_max;
      w_res_idx  = r_res_idx;
      w_best_max = r_best_max;
      w_best_idx = r_best_idx;
      w_best_frq = r_best_frq;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_state = StFeed;
               w_freq  = '0;
               w_cnt   = '0;
               w_first = 1'b1;
            end
         end
         StFeed: begin
            // Counter only moves on an accepted beat, so addresses hold under backpressure.
            if (xc.xc_s_axis_tready) begin
               if (r_cnt == LastCnt) begin
                  w_cnt   = '0;
                  w_state = StWait;
               end else begin
                  w_cnt = r_cnt + 1'b1;
               end
            end
         end
         StWait: begin
            if (xc.xc_s_axis_tvalid) begin
               w_res_max = xc.xc_out_max;
               w_res_idx = xc.xc_index;
               w_state   = StUpdate;
            end
         end
         StUpdate: begin
            // Strict compare: a tie keeps the earlier bin. First bin always loads so
            // stale results from a previous sweep never survive.
            if (r_first || (r_res_max > r_best_max)) begin
               w_best_max = r_res_max;
               w_best_idx = r_res_idx;
               w_best_frq = r_freq;
            end
            w_first = 1'b0;
            if (r_freq == LastFreq) begin
               w_state = StDone;
            end else begin
               w_freq  = r_freq + 1'b1;
               w_state = StFeed;
            end
         end
         StDone: begin
            w_state = StIdle;
         end
         default: begin
            w_state = StIdle;
         end
      endcase
   end

   assign busy                = (r_state != StIdle);
   assign done                = (r_state == StDone);
   assign xc.xc_m_axis_tvalid = (r_state == StFeed);
   assign xc.xc_m_axis_tready = (r_state == StWait);
   assign freq_index          = r_freq;
   assign x_addr              = r_cnt;
   assign y_addr              = r_cnt;
   assign best_max            = r_best_max;
   assign best_index          = r_best_idx;
   assign best_freq           = r_best_frq;

endmodule

// File: tb/tb_caf_ctrl.sv
// tb_caf_ctrl: directed bench for caf_ctrl with a small x_corr stand-in that
// applies input backpressure, returns per-bin results after a set latency and can
// inject spurious result-valid pulses while samples are being fed.
module tb_caf_ctrl;
   localparam int unsigned Length            = 5;
   localparam int unsigned LengthCounterBits = 3;
   localparam int unsigned FreqBins          = 4;
   localparam int unsigned FreqBits          = 2;
   localparam int unsigned OutMaxBits        = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       busy;
   logic       done;
   logic [1:0] freq_index;
   logic [2:0] x_addr;
   logic [2:0] y_addr;
   logic [4:0] best_max;
   logic [2:0] best_index;
   logic [1:0] best_freq;

   caf_ctrl_if #(.OutMaxBits(OutMaxBits), .LengthCounterBits(LengthCounterBits)) xc_bus ();

   caf_ctrl #(
      .Length(Length),
      .LengthCounterBits(LengthCounterBits),
      .FreqBins(FreqBins),
      .FreqBits(FreqBits),
      .OutMaxBits(OutMaxBits)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .busy(busy),
      .done(done),
      .freq_index(freq_index),
      .x_addr(x_addr),
      .y_addr(y_addr),
      .best_max(best_max),
      .best_index(best_index),
      .best_freq(best_freq),
      .xc(xc_bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // x_corr stand-in configuration
   logic [4:0] res_max [4];
   logic [2:0] res_idx [4];
   int         lat     = 1;
   bit         bp_en   = 1'b0;
   bit         spur_en = 1'b0;

   // Observation logs
   logic [1:0] beat_freq [$];
   logic [2:0] beat_x [$];
   logic [2:0] beat_y [$];
   int done_count, stall_count, hold_err, spur_count, freq_glitch;

   int         rsp_wait = 0;
   int         rsp_ptr  = 0;
   bit         rsp_prev_stall = 1'b0;
   logic [2:0] rsp_stall_addr = '0;

   // Inputs change on the falling edge; a beat is logged when valid and ready
   // are both high for the coming rising edge.
   initial begin
      xc_bus.xc_s_axis_tready = 1'b1;
      xc_bus.xc_s_axis_tvalid = 1'b0;
      xc_bus.xc_out_max       = '0;
      xc_bus.xc_index         = '0;
      forever begin
         @(negedge clk);
         xc_bus.xc_s_axis_tvalid = 1'b0;
         if (xc_bus.xc_m_axis_tvalid === 1'b1) begin
            if (rsp_prev_stall && (x_addr !== rsp_stall_addr)) hold_err++;
            xc_bus.xc_s_axis_tready = bp_en ? ((rsp_ptr % 3) == 0) : 1'b1;
            rsp_ptr++;
            if (!xc_bus.xc_s_axis_tready) begin
               stall_count++;
               rsp_prev_stall = 1'b1;
               rsp_stall_addr = x_addr;
            end else begin
               rsp_prev_stall = 1'b0;
               beat_freq.push_back(freq_index);
               beat_x.push_back(x_addr);
               beat_y.push_back(y_addr);
            end
            if (spur_en && (x_addr == 3'd2)) begin
               xc_bus.xc_s_axis_tvalid = 1'b1;
               xc_bus.xc_out_max       = 5'd31;
               xc_bus.xc_index         = 3'd7;
               spur_count++;
            end
         end else begin
            rsp_prev_stall          = 1'b0;
            xc_bus.xc_s_axis_tready = 1'b1;
         end
         if (xc_bus.xc_m_axis_tready === 1'b1) begin
            rsp_wait++;
            if ((beat_freq.size() > 0) && (freq_index !== beat_freq[$])) freq_glitch++;
            if (rsp_wait >= lat) begin
               xc_bus.xc_s_axis_tvalid = 1'b1;
               xc_bus.xc_out_max       = res_max[freq_index];
               xc_bus.xc_index         = res_idx[freq_index];
            end
         end else begin
            rsp_wait = 0;
         end
         if (done === 1'b1) done_count++;
      end
   end

   task automatic clear_logs();
      beat_freq.delete();
      beat_x.delete();
      beat_y.delete();
      done_count  = 0;
      stall_count = 0;
      hold_err    = 0;
      spur_count  = 0;
      freq_glitch = 0;
   endtask

   task automatic set_results(input logic [4:0] m0, input logic [2:0] i0,
                              input logic [4:0] m1, input logic [2:0] i1,
                              input logic [4:0] m2, input logic [2:0] i2,
                              input logic [4:0] m3, input logic [2:0] i3);
      res_max[0] = m0; res_idx[0] = i0;
      res_max[1] = m1; res_idx[1] = i1;
      res_max[2] = m2; res_idx[2] = i2;
      res_max[3] = m3; res_idx[3] = i3;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Returns at the falling edge where done is high, or ok=0 after the budget.
   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [21:0] outs;
      bit          ok;
      bit          found;
      // Power-on reset
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      outs = {busy, done, freq_index, x_addr, y_addr, xc_bus.xc_m_axis_tvalid,
              xc_bus.xc_m_axis_tready, best_max, best_index, best_freq};
      n_checks++;
      if (outs !== 22'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 000000", outs);
      end
      reset = 1'b0;
      // Reset in the middle of the third beat of bin 0
      set_results(5'd7, 3'd3, 5'd2, 3'd0, 5'd7, 3'd1, 5'd8, 3'd2);
      lat = 1;
      pulse_start();
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if ((xc_bus.xc_m_axis_tvalid === 1'b1) && (x_addr === 3'd2)) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL reset_reach_beat3: got no third beat expected one within 50 cycles");
      end
      #2 reset = 1'b1;
      #1;
      outs = {busy, done, freq_index, x_addr, y_addr, xc_bus.xc_m_axis_tvalid,
              xc_bus.xc_m_axis_tready, best_max, best_index, best_freq};
      n_checks++;
      if (outs !== 22'd0) begin
         n_fail++;
         $display("FAIL reset_midfeed_outputs: got %h expected 000000", outs);
      end
      @(negedge clk);
      reset = 1'b0;
      clear_logs();
      repeat (3) @(negedge clk);
      n_checks++;
      if ((busy !== 1'b0) || (xc_bus.xc_m_axis_tvalid !== 1'b0) || (beat_x.size() != 0)) begin
         n_fail++;
         $display("FAIL reset_stays_idle: got busy=%b valid=%b beats=%0d expected 0 0 0",
                  busy, xc_bus.xc_m_axis_tvalid, beat_x.size());
      end
      // A fresh sweep after reset runs normally
      pulse_start();
      wait_done(ok);
      @(negedge clk);
      n_checks++;
      if (!ok || ({best_max, best_index, best_freq} !== {5'd8, 3'd2, 2'd3})) begin
         n_fail++;
         $display("FAIL reset_resweep_best: got ok=%b %0d/%0d/%0d expected 1 8/2/3",
                  ok, best_max, best_index, best_freq);
      end
      n_checks++;
      if ((beat_x.size() != 20) || (done_count != 1)) begin
         n_fail++;
         $display("FAIL reset_resweep_counts: got beats=%0d dones=%0d expected 20 1",
                  beat_x.size(), done_count);
      end
   endtask

   task automatic test_basic_sweep();
      bit ok;
      clear_logs();
      set_results(5'd3, 3'd1, 5'd9, 3'd4, 5'd9, 3'd2, 5'd5, 3'd0);
      lat = 2;
      pulse_start();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_busy_after_start: got %b expected 1", busy);
      end
      wait_done(ok);
      @(negedge clk);
      n_checks++;
      if (!ok || ({best_max, best_index, best_freq} !== {5'd9, 3'd4, 2'd1})) begin
         n_fail++;
         $display("FAIL basic_best: got ok=%b %0d/%0d/%0d expected 1 9/4/1",
                  ok, best_max, best_index, best_freq);
      end
      n_checks++;
      if ((done_count != 1) || (busy !== 1'b0) || (done !== 1'b0)) begin
         n_fail++;
         $display("FAIL basic_done_busy: got dones=%0d busy=%b done=%b expected 1 0 0",
                  done_count, busy, done);
      end
      n_checks++;
      if (beat_x.size() != 20) begin
         n_fail++;
         $display("FAIL basic_beat_count: got %0d expected 20", beat_x.size());
      end else begin
         for (int i = 0; i < 20; i++) begin
            n_checks++;
            if ({beat_freq[i], beat_x[i], beat_y[i]} !== {2'(i / 5), 3'(i % 5), 3'(i % 5)}) begin
               n_fail++;
               $display("FAIL basic_beat_%0d: got f=%0d x=%0d y=%0d expected f=%0d x=y=%0d",
                        i, beat_freq[i], beat_x[i], beat_y[i], i / 5, i % 5);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      clear_logs();
      set_results(5'd4, 3'd2, 5'd6, 3'd3, 5'd1, 3'd0, 5'd6, 3'd1);
      lat = 1;
      bp_en = 1'b1;
      rsp_ptr = 0;
      pulse_start();
      wait_done(ok);
      @(negedge clk);
      bp_en = 1'b0;
      n_checks++;
      if (!ok || ({best_max, best_index, best_freq} !== {5'd6, 3'd3, 2'd1})) begin
         n_fail++;
         $display("FAIL bp_best: got ok=%b %0d/%0d/%0d expected 1 6/3/1",
                  ok, best_max, best_index, best_freq);
      end
      n_checks++;
      if ((stall_count == 0) || (hold_err != 0)) begin
         n_fail++;
         $display("FAIL bp_hold: got stalls=%0d hold_errors=%0d expected >0 0",
                  stall_count, hold_err);
      end
      n_checks++;
      if (beat_x.size() != 20) begin
         n_fail++;
         $display("FAIL bp_beat_count: got %0d expected 20", beat_x.size());
      end else begin
         for (int i = 0; i < 20; i++) begin
            n_checks++;
            if ({beat_freq[i], beat_x[i], beat_y[i]} !== {2'(i / 5), 3'(i % 5), 3'(i % 5)}) begin
               n_fail++;
               $display("FAIL bp_beat_%0d: got f=%0d x=%0d y=%0d expected f=%0d x=y=%0d",
                        i, beat_freq[i], beat_x[i], beat_y[i], i / 5, i % 5);
            end
         end
      end
   endtask

   task automatic test_all_zero();
      bit ok;
      clear_logs();
      set_results(5'd0, 3'd2, 5'd0, 3'd1, 5'd0, 3'd4, 5'd0, 3'd3);
      lat = 1;
      pulse_start();
      wait_done(ok);
      @(negedge clk);
      n_checks++;
      if (!ok || ({best_max, best_index, best_freq} !== {5'd0, 3'd2, 2'd0})) begin
         n_fail++;
         $display("FAIL zero_best: got ok=%b %0d/%0d/%0d expected 1 0/2/0",
                  ok, best_max, best_index, best_freq);
      end
   endtask

   task automatic test_start_ignored();
      bit ok;
      bit found;
      clear_logs();
      set_results(5'd5, 3'd1, 5'd5, 3'd2, 5'd2, 3'd3, 5'd1, 3'd4);
      lat = 3;
      pulse_start();
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (xc_bus.xc_m_axis_tready === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL ign_reach_wait: got no WAIT expected one within 50 cycles");
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(ok);
      start = 1'b1;  // sampled while in DONE
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (!ok || (busy !== 1'b0)) begin
         n_fail++;
         $display("FAIL ign_busy_after_done: got ok=%b busy=%b expected 1 0", ok, busy);
      end
      repeat (5) @(negedge clk);
      n_checks++;
      if ((done_count != 1) || (busy !== 1'b0) || (beat_x.size() != 20)) begin
         n_fail++;
         $display("FAIL ign_single_sweep: got dones=%0d busy=%b beats=%0d expected 1 0 20",
                  done_count, busy, beat_x.size());
      end
      n_checks++;
      if ({best_max, best_index, best_freq} !== {5'd5, 3'd1, 2'd0}) begin
         n_fail++;
         $display("FAIL ign_best: got %0d/%0d/%0d expected 5/1/0",
                  best_max, best_index, best_freq);
      end
      // New sweep from IDLE overwrites best_*
      clear_logs();
      set_results(5'd10, 3'd4, 5'd3, 3'd0, 5'd12, 3'd2, 5'd12, 3'd1);
      pulse_start();
      wait_done(ok);
      @(negedge clk);
      n_checks++;
      if (!ok || (done_count != 1) ||
          ({best_max, best_index, best_freq} !== {5'd12, 3'd2, 2'd2})) begin
         n_fail++;
         $display("FAIL ign_resweep_best: got ok=%b dones=%0d %0d/%0d/%0d expected 1 1 12/2/2",
                  ok, done_count, best_max, best_index, best_freq);
      end
   endtask

   task automatic test_delayed_result();
      bit ok;
      clear_logs();
      set_results(5'd4, 3'd1, 5'd6, 3'd2, 5'd2, 3'd0, 5'd3, 3'd3);
      lat = 50;
      spur_en = 1'b1;
      pulse_start();
      wait_done(ok);
      @(negedge clk);
      spur_en = 1'b0;
      n_checks++;
      if (!ok || ({best_max, best_index, best_freq} !== {5'd6, 3'd2, 2'd1})) begin
         n_fail++;
         $display("FAIL delay_best: got ok=%b %0d/%0d/%0d expected 1 6/2/1",
                  ok, best_max, best_index, best_freq);
      end
      n_checks++;
      if ((spur_count == 0) || (freq_glitch != 0) || (beat_x.size() != 20)) begin
         n_fail++;
         $display("FAIL delay_stability: got spur=%0d glitches=%0d beats=%0d expected >0 0 20",
                  spur_count, freq_glitch, beat_x.size());
      end
      n_checks++;
      if (done_count != 1) begin
         n_fail++;
         $display("FAIL delay_done_count: got %0d expected 1", done_count);
      end
   endtask

   initial begin
      clear_logs();
      set_results(5'd0, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0);
      test_reset();
      test_basic_sweep();
      test_backpressure();
      test_all_zero();
      test_start_ignored();
      test_delayed_result();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
